// File: rtl/zx81_tape_player.sv
// zx81_tape_player: replays a .p/.o image from tape RAM as a ZX81/ZX80 cassette pulse waveform
module zx81_tape_player #(
    parameter int PULSE_T  = 488,
    parameter int GAP_T    = 4225,
    parameter int LEADER_T = 3250000,
    parameter bit NAME_EN  = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic        stop,
    input  logic        zx80,
    input  logic [13:0] last_addr,
    output logic [13:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        tape_out,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, LEADER, FETCH, LATCH, BITSTART, PHI, PLO, GAP} state_t;
    localparam logic [21:0] PT = 22'(PULSE_T);
    localparam logic [21:0] GT = 22'(GAP_T);
    localparam logic [21:0] LT = 22'(LEADER_T);
    state_t state, state_n;
    logic [21:0] tmr, tmr_n;
    logic [3:0] pcnt, pcnt_n;
    logic [2:0] bitn, bitn_n;
    logic [7:0] sreg, sreg_n;
    logic [13:0] rd_addr_n;
    logic tape_n, done_n, in_name, in_name_n, timed, expired;
    assign timed = state inside {LEADER, PHI, PLO, GAP};
    assign expired = ce && tmr == 22'd1;
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        tmr_n = (ce && timed) ? tmr - 22'd1 : tmr;
        pcnt_n = pcnt;
        bitn_n = bitn;
        sreg_n = sreg;
        rd_addr_n = rd_addr;
        tape_n = tape_out;
        in_name_n = in_name;
        done_n = 1'b0;
        case (state)
            LEADER: if (expired) begin
                if (NAME_EN && !zx80) begin
                    sreg_n = 8'h80;
                    bitn_n = 3'd7;
                    in_name_n = 1'b1;
                    state_n = BITSTART;
                end else state_n = FETCH;
            end
            FETCH: state_n = LATCH;
            LATCH: begin
                sreg_n = rd_data;
                bitn_n = 3'd7;
                state_n = BITSTART;
            end
            BITSTART: begin
                pcnt_n = sreg[bitn] ? 4'd9 : 4'd4;
                tmr_n = PT;
                tape_n = 1'b1;
                state_n = PHI;
            end
            PHI: if (expired) begin
                tape_n = 1'b0;
                tmr_n = PT;
                state_n = PLO;
            end
            PLO: if (expired) begin
                pcnt_n = pcnt - 4'd1;
                tape_n = pcnt != 4'd1;
                tmr_n = (pcnt != 4'd1) ? PT : GT;
                state_n = (pcnt != 4'd1) ? PHI : GAP;
            end
            GAP: if (expired) begin
                if (bitn != 3'd0) begin
                    bitn_n = bitn - 3'd1;
                    state_n = BITSTART;
                end else if (in_name) begin
                    in_name_n = 1'b0;
                    rd_addr_n = '0;
                    state_n = FETCH;
                end else if (rd_addr == last_addr) begin
                    done_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    rd_addr_n = rd_addr + 14'd1;
                    state_n = FETCH;
                end
            end
            default: ;
        endcase
        // stop is applied last so it wins over a simultaneous start
        if (start) begin
            state_n = LEADER;
            rd_addr_n = '0;
            tmr_n = LT;
            tape_n = 1'b0;
            in_name_n = 1'b0;
            done_n = 1'b0;
        end
        if (stop) begin
            state_n = IDLE;
            tape_n = 1'b0;
            in_name_n = 1'b0;
            done_n = 1'b0;
        end
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            tmr <= '0;
            pcnt <= '0;
            bitn <= '0;
            sreg <= '0;
            rd_addr <= '0;
            tape_out <= 1'b0;
            in_name <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            tmr <= tmr_n;
            pcnt <= pcnt_n;
            bitn <= bitn_n;
            sreg <= sreg_n;
            rd_addr <= rd_addr_n;
            tape_out <= tape_n;
            in_name <= in_name_n;
            done <= done_n;
        end
    end
endmodule

// File: tb/tb_zx81_tape_player.sv
// tb_zx81_tape_player: directed vector bench for the cassette player, NAME_EN=0 and NAME_EN=1 instances
module tb_zx81_tape_player;
    logic clk_sys = 1'b0, reset = 1'b1, ce = 1'b1, start = 1'b0, stop = 1'b0, zx80 = 1'b0, sel = 1'b0;
    logic [13:0] last_addr = '0, a0, a1, cur_a;
    logic [7:0] rd0, rd1;
    logic [7:0] ram [0:3];
    logic t0, b0, dn0, t1, b1, dn1, cur_t, cur_b, cur_d;
    int checks = 0, fails = 0;
    typedef struct {
        logic sel;
        logic zx;
        logic [13:0] la;
        logic [7:0] m0, m1, m2;
        int er, ef, et;
    } vec_t;
    vec_t v [6];
    always #5 clk_sys = ~clk_sys;
    zx81_tape_player #(.PULSE_T(4), .GAP_T(20), .LEADER_T(50), .NAME_EN(1'b0)) d0 (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .start(start), .stop(stop), .zx80(zx80),
        .last_addr(last_addr), .rd_addr(a0), .rd_data(rd0), .tape_out(t0), .busy(b0), .done(dn0));
    zx81_tape_player #(.PULSE_T(4), .GAP_T(20), .LEADER_T(50), .NAME_EN(1'b1)) d1 (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .start(start), .stop(stop), .zx80(zx80),
        .last_addr(last_addr), .rd_addr(a1), .rd_data(rd1), .tape_out(t1), .busy(b1), .done(dn1));
    always @(posedge clk_sys) begin
        rd0 <= ram[a0[1:0]];
        rd1 <= ram[a1[1:0]];
    end
    assign cur_t = sel ? t1 : t0;
    assign cur_b = sel ? b1 : b0;
    assign cur_d = sel ? dn1 : dn0;
    assign cur_a = sel ? a1 : a0;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic setup(input vec_t r);
        sel = r.sel;
        zx80 = r.zx;
        last_addr = r.la;
        ram[0] = r.m0;
        ram[1] = r.m1;
        ram[2] = r.m2;
        ram[3] = 8'h00;
    endtask
    task automatic pulse(input bit is_stop);
        if (is_stop) stop = 1'b1; else start = 1'b1;
        @(negedge clk_sys);
        stop = 1'b0;
        start = 1'b0;
    endtask
    task automatic run_case(input vec_t r, input int idx);
        int cyc = 0, rises = 0, first = 0, hi = 0, badw = 0, maxa = 0, bz = 1;
        logic pt, got = 1'b0;
        setup(r);
        @(negedge clk_sys);
        pulse(1'b0);
        while (!got && cyc < 4000) begin
            pt = cur_t;
            @(negedge clk_sys);
            cyc++;
            if (pt && ce) hi++;
            if (!pt && cur_t) begin
                rises++;
                if (first == 0) first = cyc;
            end
            if (pt && !cur_t) begin
                if (hi != 4) badw++;
                hi = 0;
            end
            if (int'(cur_a) > maxa) maxa = int'(cur_a);
            if (cur_d) begin
                got = 1'b1;
                bz = int'(cur_b);
            end
        end
        check($sformatf("row%0d rising edges", idx), rises, r.er);
        check($sformatf("row%0d leader length", idx), first, r.ef);
        check($sformatf("row%0d cycles to done", idx), cyc, r.et);
        check($sformatf("row%0d bad pulse widths", idx), badw, 0);
        check($sformatf("row%0d max rd_addr", idx), maxa, int'(r.la));
        check($sformatf("row%0d final rd_addr", idx), int'(cur_a), int'(r.la));
        check($sformatf("row%0d busy at done", idx), bz, 0);
        @(negedge clk_sys);
        check($sformatf("row%0d done one cycle", idx), int'(cur_d), 0);
    endtask
    task automatic wait_rises(input int n, input int bound);
        int k = 0, r = 0;
        logic pt;
        while (r < n && k < bound) begin
            pt = cur_t;
            @(negedge clk_sys);
            k++;
            if (!pt && cur_t) r++;
        end
        check("rise wait in time", r, n);
    endtask
    task automatic wait_addr1();
        int k = 0;
        while (cur_a != 14'd1 && k < 1500) begin
            @(negedge clk_sys);
            k++;
        end
        check("rd_addr reached 1", int'(cur_a), 1);
    endtask
    initial begin
        int hi, drops, k, extra_r, extra_d;
        logic pt, pc;
        for (int i = 0; i < 4; i++) ram[i] = 8'h00;
        v[0] = '{1'b0, 1'b0, 14'd0, 8'h80, 8'h00, 8'h00, 37, 53, 516};
        v[1] = '{1'b1, 1'b0, 14'd0, 8'h00, 8'h00, 8'h00, 69, 51, 940};
        v[2] = '{1'b1, 1'b1, 14'd0, 8'h00, 8'h00, 8'h00, 32, 53, 476};
        v[3] = '{1'b0, 1'b0, 14'd2, 8'hFF, 8'h00, 8'h01, 141, 53, 1688};
        v[4] = '{1'b1, 1'b0, 14'd2, 8'hFF, 8'h00, 8'h01, 178, 51, 2152};
        v[5] = '{1'b0, 1'b0, 14'd1, 8'h00, 8'hFF, 8'h00, 104, 53, 1222};
        start = 1'b1;
        repeat (3) @(negedge clk_sys);
        start = 1'b0;
        check("reset tape_out", int'(t0), 0);
        check("reset busy", int'(b0), 0);
        check("reset done", int'(dn0), 0);
        check("reset rd_addr", int'(a0), 0);
        check("reset d1 outputs", int'({t1, b1, dn1, a1}), 0);
        reset = 1'b0;
        @(negedge clk_sys);
        check("idle after reset", int'({b0, b1}), 0);
        for (int i = 0; i < 6; i++) run_case(v[i], i);
        // stop in the third pulse of byte 0, then nothing more may happen
        setup(v[0]);
        pulse(1'b0);
        wait_rises(3, 400);
        check("third pulse high", int'(t0), 1);
        pulse(1'b1);
        check("stop tape_out", int'(t0), 0);
        check("stop busy", int'(b0), 0);
        check("stop done", int'(dn0), 0);
        extra_r = 0;
        extra_d = 0;
        for (int i = 0; i < 600; i++) begin
            pt = t0;
            @(negedge clk_sys);
            if (!pt && t0) extra_r++;
            if (dn0) extra_d++;
        end
        check("edges after stop", extra_r, 0);
        check("done after stop", extra_d, 0);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        stop = 1'b0;
        check("stop beats start", int'(b0), 0);
        run_case(v[0], 6);
        // ce held low in the middle of a high pulse
        setup(v[0]);
        pulse(1'b0);
        wait_rises(1, 100);
        hi = 0;
        drops = 0;
        for (int i = 0; i < 2; i++) begin
            pt = t0;
            pc = ce;
            @(negedge clk_sys);
            if (pt && pc) hi++;
        end
        ce = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            if (!t0) drops++;
        end
        check("tape held during ce low", drops, 0);
        ce = 1'b1;
        k = 0;
        while (t0 && k < 20) begin
            pc = ce;
            @(negedge clk_sys);
            hi++;
            k++;
        end
        check("pulse width across ce hold", hi, 4);
        pulse(1'b1);
        // reset while in the gap after the first bit of byte 1
        setup(v[3]);
        pulse(1'b0);
        wait_addr1();
        wait_rises(4, 200);
        k = 0;
        while (t0 && k < 20) begin
            @(negedge clk_sys);
            k++;
        end
        repeat (10) @(negedge clk_sys);
        check("in gap before reset", int'({t0, b0}), 1);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check("reset mid-gap outputs", int'({t0, b0, dn0}), 0);
        check("reset mid-gap rd_addr", int'(a0), 0);
        // start while busy restarts from the leader at address 0
        pulse(1'b0);
        wait_addr1();
        pulse(1'b0);
        check("restart rd_addr", int'(a0), 0);
        check("restart busy", int'(b0), 1);
        check("restart tape_out", int'(t0), 0);
        pulse(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule

// File: doc/zx81_tape_player.md
Name: zx81_tape_player

Overview:
- Plays a .p/.o image from tape RAM as a real ZX81/ZX80 cassette waveform on the `tape_in` bit (bit 7 of the keyboard port read).
- Sits directly upstream of the CPU's port-FE read mux. It is the alternative to the ROM-patch fast loader for software that uses custom loaders.
- Reads bytes from the 16 KB tape RAM through a 1-cycle-latency read port. Each bit is serialised MSB first as a pulse burst followed by a gap.

Parameters:
- PULSE_T, 488: ce ticks per pulse half-period (150 us at 3.25 MHz).
- GAP_T, 4225: ce ticks of low level after each bit (1300 us).
- LEADER_T, 3250000: ce ticks of silence before the first byte (1 s).
- NAME_EN, 1: 1 = emit one name byte 8'h80 before the data (the empty name matches LOAD ""); 0 = no name byte.

Ports:
- clk_sys, in, 1: system clock (52 MHz).
- reset, in, 1: synchronous, active-high.
- ce, in, 1: timing enable, 3.25 MHz strobe (ce_3m25); all timers advance only on ce.
- start, in, 1: 1-cycle pulse; begins playback from address 0.
- stop, in, 1: 1-cycle pulse; aborts playback.
- zx80, in, 1: 1 = ZX80 mode (no name byte regardless of NAME_EN).
- last_addr, in, 14: address of the final valid image byte (ioctl_addr at download end).
- rd_addr, out, 14: tape RAM read address.
- rd_data, in, 8: tape RAM data; valid 1 clk_sys cycle after rd_addr changes.
- tape_out, out, 1: cassette level, 1 = pulse high.
- busy, out, 1: high while in any state other than IDLE.
- done, out, 1: 1-cycle pulse when the last gap completes.

Behaviour:
- Reset values: tape_out=0, busy=0, done=0, rd_addr=0, state=IDLE.
- Timer: 22-bit down-counter `tmr`, decremented on ce. A phase ends on the ce where tmr==1. Loading tmr with N gives exactly N ce ticks.
- Bit counter `bitn` counts 7..0 and selects the current bit of the shift register.
- Pulse counter `pcnt` is loaded with 4 for a 0 bit and 9 for a 1 bit.
- States and transitions:
  - IDLE: on start, set rd_addr=0, load tmr=LEADER_T, go to LEADER.
  - LEADER: tape_out=0. When the timer expires: if NAME_EN & ~zx80, load sreg=8'h80 and go to BITSTART; otherwise go to FETCH.
  - FETCH: wait one clk_sys cycle for RAM latency, then go to LATCH.
  - LATCH: sreg=rd_data, bitn=7, go to BITSTART.
  - BITSTART: pcnt = sreg[bitn] ? 9 : 4, tmr=PULSE_T, tape_out=1, go to PHI.
  - PHI: on expiry, tape_out=0, tmr=PULSE_T, go to PLO.
  - PLO: on expiry, pcnt-=1. If pcnt≠0, tape_out=1 and go to PHI. Otherwise tmr=GAP_T and go to GAP.
  - GAP: tape_out=0. On expiry:
    - if bitn≠0: bitn-=1, go to BITSTART;
    - else if the byte was the name byte: rd_addr=0, go to FETCH;
    - else if rd_addr==last_addr: done=1, go to IDLE;
    - else rd_addr+=1, go to FETCH.
- Name byte handling: a flag `in_name` marks the name byte. Its bitn starts at 7 in the LEADER exit.
- Bit period: one 0-bit = (8·PULSE_T + GAP_T) ce ticks; one 1-bit = (18·PULSE_T + GAP_T) ce ticks.
- Addressing: rd_addr never exceeds last_addr. last_addr=0 plays exactly 1 byte. No wrap-around occurs at 14'h3FFF, because playback ends there when last_addr=14'h3FFF.
- Boundary conditions:
  - stop, or reset mid-operation: immediately IDLE, tape_out=0, busy=0, no done pulse. stop has priority over a simultaneous start.
  - start while busy: restarts from LEADER with rd_addr=0.
  - ce low: the state holds and tape_out is stable. FETCH/LATCH are not ce-gated.
  - last_addr changing during play: sampled at each GAP end, not latched.

Test Plan:
- Params PULSE_T=4, GAP_T=20, LEADER_T=50, NAME_EN=0; RAM[0]=8'h80, last_addr=0; start -> tape_out low for 50 ce. First bit: 9 high pulses, each 4 ce high / 4 ce low. Then 7 bits of 4 pulses, each bit followed by a 20-ce gap. done pulses once; busy falls the same cycle.
- NAME_EN=1, zx80=0, RAM[0]=8'h00, last_addr=0 -> the name byte 8'h80 pattern precedes 8 zero-bits (4 pulses each). Total rising edges = 9+7·4+8·4 = 69.
- Same setup with zx80=1 -> no name byte; exactly 32 rising edges.
- last_addr=2, RAM={8'hFF,8'h00,8'h01} -> rd_addr sequence 0,1,2. Rising edges 72+32+37=141. done asserts only after the final gap.
- stop asserted during the 3rd pulse of byte 0 -> the next cycle has tape_out=0 and busy=0, with no done. A following start replays from LEADER with rd_addr=0.
- ce held low for 100 cycles mid-PHI -> tape_out stays 1 and the pulse width is still exactly 4 ce ticks. reset asserted mid-GAP -> all outputs return to their reset values on the next clk_sys edge.
